// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared constants for the UART transmitter and its peer receiver
//
// Contents:
//   BAUD*        common line rates in bit/s
//   DATA_BITS    payload bits per frame
//   PARITY_*     parity sense selectors
//   ST_*         frame FSM state encodings
//   parity_bit() parity bit for a payload byte
package uart_tx_pkg;

    localparam int BAUD9600   = 9600;
    localparam int BAUD115200 = 115200;
    localparam int BAUD1M     = 1000000;
    localparam int BAUD8M     = 8000000;

    localparam int DATA_BITS   = 8;
    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Bit that makes data+parity reduce to 0 (even) or 1 (odd).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - clock-enable tick every CLKS_PER_BIT system clocks
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   clear_i  synchronous restart; count returns to 0 on the next edge
//   tick_o   high for one cycle on the terminal count (CLKS_PER_BIT-1)
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB-first, parity, stop bit(s)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, sampled when a request is accepted
//   tx_start  request strobe, accepted while idle
//   tx        registered serial line, idles high
//   tx_busy   high from the cycle after acceptance until stop completes
//   tx_done   one-cycle pulse at frame completion
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 24000000,
    parameter int BAUD_RATE = BAUD8M,
    parameter int PARITY    = PARITY_EVEN,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic [2:0]           state_q,   state_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 parity_q,  parity_d;
    logic                 tx_q,      tx_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic baud_clear;
    logic baud_tick;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(baud_clear),
        .tick_o (baud_tick)
    );

    // tx is computed one state ahead so the line changes exactly at the
    // edge that enters the new state, keeping the output a plain flop.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        baud_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d    = tx_data;
                    parity_d   = parity_bit(tx_data, 1'(PARITY));
                    baud_clear = 1'b1;
                    bit_idx_d  = '0;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_DATA) begin
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx in two configurations
module tb_uart_tx;

    typedef struct {
        logic [7:0] d;
        bit         b2b;
        bit         abort;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_r  [2];
    logic       start_r [2];
    logic       tx_w    [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    exp_t q0[$];
    exp_t q1[$];

    int cmp_cnt = 0;
    int err_cnt = 0;

    // dut0: 3 clocks/bit, even parity, 1 stop; dut1: 3 clocks/bit, odd parity, 2 stops
    uart_tx #(.CLK_FREQ(24000000), .BAUD_RATE(8000000), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[0]), .tx_start(start_r[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx #(.CLK_FREQ(24000000), .BAUD_RATE(8000000), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[1]), .tx_start(start_r[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int stops(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic void push(input int k, input logic [7:0] d, input bit b2b, input bit abort);
        exp_t e;
        e.d = d; e.b2b = b2b; e.abort = abort;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    // Expected line bits of one frame, index = bit period: start, data LSB first,
    // parity chosen so the count of ones in data+parity is even (k=0) or odd (k=1), stops.
    function automatic logic [11:0] frame_bits(input int k, input logic [7:0] d);
        logic [11:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[1+i] = d[i];
            ones += int'(d[i]);
        end
        f[9] = ((ones + k) % 2) == 1;
        for (int s = 0; s < stops(k); s++) f[10+s] = 1'b1;
        return f;
    endfunction

    task automatic monitor(input int k);
        int nf;
        int extra;
        bit aborted, stable, busy_ok, done_ok, got;
        logic [11:0] obs;
        exp_t e;
        nf = (10 + stops(k)) * 3;
        extra = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                extra = -1;
                continue;
            end
            if (tx_w[k] !== 1'b0) begin
                if (extra >= 0) extra++;
                continue;
            end
            got = 1'b0;
            if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            if (!got) begin
                check($sformatf("dut%0d unexpected_frame", k), 32'd1, 32'd0);
                e.d = 8'h00; e.b2b = 1'b0; e.abort = 1'b0;
            end
            if (e.b2b) check($sformatf("dut%0d b2b_extra_idle", k), extra, 0);
            obs = '0; stable = 1'b1; busy_ok = 1'b1; done_ok = 1'b1; aborted = 1'b0;
            for (int c = 0; c < nf; c++) begin
                if (c > 0) @(negedge clk);
                if (!rst_n) begin
                    aborted = 1'b1;
                    break;
                end
                if (c % 3 == 0) obs[c/3] = tx_w[k];
                else if (tx_w[k] !== obs[c/3]) stable = 1'b0;
                if (busy_w[k] !== 1'b1) busy_ok = 1'b0;
                if (done_w[k] !== 1'b0) done_ok = 1'b0;
            end
            check($sformatf("dut%0d aborted d=%02h", k, e.d), 32'(aborted), 32'(e.abort));
            if (aborted) begin
                extra = -1;
                continue;
            end
            check($sformatf("dut%0d frame d=%02h", k, e.d), 32'(obs), 32'(frame_bits(k, e.d)));
            check($sformatf("dut%0d bit_stable", k), 32'(stable), 32'd1);
            check($sformatf("dut%0d busy_in_frame", k), 32'(busy_ok), 32'd1);
            check($sformatf("dut%0d no_early_done", k), 32'(done_ok), 32'd1);
            @(negedge clk);
            check($sformatf("dut%0d end {done,busy,tx}", k), {29'd0, done_w[k], busy_w[k], tx_w[k]}, 32'b101);
            extra = 0;
        end
    endtask

    // Called at a negedge while the DUT is idle or in its tx_done cycle.
    task automatic issue(input int k, input logic [7:0] d, input bit b2b);
        data_r[k] = d;
        start_r[k] = 1'b1;
        push(k, d, b2b, 1'b0);
        @(negedge clk);
        start_r[k] = 1'b0;
        data_r[k] = ~d;
        check($sformatf("dut%0d start_latency {tx,busy}", k), {30'd0, tx_w[k], busy_w[k]}, 32'b01);
    endtask

    task automatic wait_done(input int k);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (done_w[k] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check($sformatf("dut%0d done_timeout", k), 32'd0, 32'd1);
    endtask

    task automatic run_seq(input int k, input int n, input bit sweep);
        int gap;
        bit b2b;
        b2b = 1'b0;
        for (int i = 0; i < n; i++) begin
            issue(k, sweep ? 8'(i) : 8'($urandom), b2b);
            wait_done(k);
            gap = $urandom_range(0, 2);
            b2b = (gap == 0);
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            data_r[k] = 8'h00;
            start_r[k] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("dut%0d reset {tx,busy,done}", k), {29'd0, tx_w[k], busy_w[k], done_w[k]}, 32'b100);
        @(negedge clk);
        #1 rst_n = 1'b1;

        fork
            monitor(0);
            monitor(1);
        join_none

        @(negedge clk);
        fork
            begin
                issue(0, 8'hA5, 1'b0); wait_done(0); @(negedge clk);
                issue(0, 8'h07, 1'b0); wait_done(0); @(negedge clk);
                issue(0, 8'h00, 1'b0); wait_done(0); @(negedge clk);
            end
            begin
                issue(1, 8'hA5, 1'b0); wait_done(1); @(negedge clk);
                issue(1, 8'h00, 1'b0); wait_done(1); @(negedge clk);
                issue(1, 8'h07, 1'b0); wait_done(1); @(negedge clk);
            end
        join

        // tx_start held high across two frames; data changes mid-frame must not leak in
        data_r[0] = 8'h3C;
        start_r[0] = 1'b1;
        push(0, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        data_r[0] = 8'h81;
        push(0, 8'h81, 1'b1, 1'b0);
        repeat (33) @(negedge clk);
        check("dut0 held_start done_cycle", 32'(done_w[0]), 32'd1);
        @(negedge clk);
        start_r[0] = 1'b0;
        data_r[0] = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            repeat (5) @(negedge clk);
            start_r[0] = 1'b1;
            @(negedge clk);
            start_r[0] = 1'b0;
        end
        wait_done(0);
        repeat (45) @(negedge clk);

        // asynchronous reset in the middle of DATA (all-zero byte keeps the line low)
        data_r[0] = 8'h00;
        start_r[0] = 1'b1;
        push(0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("dut0 pre_reset_in_data tx", 32'(tx_w[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1 check("dut0 async_reset {tx,busy,done}", {29'd0, tx_w[0], busy_w[0], done_w[0]}, 32'b100);
        repeat (3) @(negedge clk);
        check("dut0 reset_hold {tx,busy,done}", {29'd0, tx_w[0], busy_w[0], done_w[0]}, 32'b100);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(0, 8'h5A, 1'b0);
        wait_done(0);
        @(negedge clk);

        fork
            run_seq(0, 256, 1'b1);
            run_seq(1, 256, 1'b1);
        join
        @(negedge clk);
        fork
            run_seq(0, 40, 1'b0);
            run_seq(1, 40, 1'b0);
        join

        repeat (60) @(negedge clk);
        check("dut0 scoreboard_empty", q0.size(), 0);
        check("dut1 scoreboard_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
